fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_adder32.sv | 11 +
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        FETCH    = 3'd1,
        HOLD     = 3'd2,
        DRAIN    = 3'd3,
        TRAP     = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_adder32.sv
// 32-bit wrap-around adder used for the sequential PC increment.
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    // Plain modulo-2^32 sum; carry out is intentionally dropped.
    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, single-entry output
// register, redirect handling with drain of in-flight responses, and a
// sticky trap on misaligned redirect targets.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RST_WAIT | first cycle after reset, no request
//   FETCH    | request at addr_q outstanding, response will be delivered
//   HOLD     | instruction held on instr_o until consumer takes it
//   DRAIN    | request at addr_q outstanding, response will be discarded
//   TRAP     | misaligned redirect seen, idle until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misaligned_o,
    output logic [31:0] fetch_cnt_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         mis_q, mis_d;
    logic         trap_pend_q, trap_pend_d;
    logic [31:0]  pc_inc;
    logic         redir_al, redir_mis;

    adder32 u_pc_adder (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .sum_o (pc_inc)
    );

    assign redir_al  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign redir_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    assign imem_req_o    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign misaligned_o  = mis_q;
    assign fetch_cnt_o   = cnt_q;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RST_WAIT;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            instr_q     <= 32'd0;
            ipc_q       <= 32'd0;
            cnt_q       <= 32'd0;
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
            trap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            mis_q       <= mis_d;
            trap_pend_q <= trap_pend_d;
        end
    end

    // Next-state logic; redirects outrank ack and stall in every state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        mis_d       = mis_q;
        trap_pend_d = trap_pend_q;
        case (state_q)
            RST_WAIT: begin
                if (redir_mis) begin
                    mis_d   = 1'b1;
                    state_d = TRAP;
                end else begin
                    state_d = FETCH;
                    if (redir_al) begin
                        pc_d   = redirect_pc_i;
                        addr_d = redirect_pc_i;
                    end
                end
            end
            FETCH: begin
                if (redir_mis) begin
                    mis_d   = 1'b1;
                    valid_d = 1'b0;
                    if (imem_ack_i) begin
                        state_d = TRAP;
                    end else begin
                        trap_pend_d = 1'b1;
                        state_d     = DRAIN;
                    end
                end else if (redir_al) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc_i;
                    if (imem_ack_i) begin
                        addr_d  = redirect_pc_i;
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ipc_d   = addr_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir_mis) begin
                    mis_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = TRAP;
                end else if (redir_al) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc_i;
                    addr_d  = redirect_pc_i;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redir_mis) begin
                    mis_d       = 1'b1;
                    valid_d     = 1'b0;
                    trap_pend_d = 1'b1;
                end else if (redir_al) begin
                    pc_d = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    if (trap_pend_q || redir_mis) begin
                        state_d = TRAP;
                    end else begin
                        addr_d  = pc_d;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misaligned_o;
    logic [31:0] fetch_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .misaligned_o  (misaligned_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Transaction-level model: is a request outstanding, will its response be
    // thrown away, is a word being held for the consumer, are we dead.
    logic        m_boot, m_req, m_disc, m_trap, m_trap_after;
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_mis;

    function automatic void model_reset();
        m_boot = 1'b1; m_req = 1'b0; m_disc = 1'b0; m_trap = 1'b0; m_trap_after = 1'b0;
        m_pc = RST_PC; m_addr = RST_PC; m_instr = 32'd0; m_ipc = 32'd0; m_cnt = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0;
    endfunction

    function automatic void model_step(input logic redir, input logic [31:0] rpc,
                                       input logic ack, input logic [31:0] rdata,
                                       input logic stall);
        logic mis, al;
        mis = redir && (rpc[1:0] != 2'b00);
        al  = redir && !mis;
        if (m_trap) return;
        if (m_boot) begin
            m_boot = 1'b0;
            if (mis) begin m_mis = 1'b1; m_trap = 1'b1; end
            else begin
                if (al) begin m_pc = rpc; m_addr = rpc; end
                m_req = 1'b1;
            end
        end else if (m_req && !m_disc) begin
            if (mis) begin
                m_mis = 1'b1;
                if (ack) begin m_req = 1'b0; m_trap = 1'b1; end
                else begin m_disc = 1'b1; m_trap_after = 1'b1; end
            end else if (al) begin
                m_pc = rpc;
                if (ack) m_addr = rpc; else m_disc = 1'b1;
            end else if (ack) begin
                m_instr = rdata; m_ipc = m_addr; m_valid = 1'b1; m_req = 1'b0;
            end
        end else if (m_req) begin
            if (mis) begin m_mis = 1'b1; m_trap_after = 1'b1; end
            else if (al) m_pc = rpc;
            if (ack) begin
                m_disc = 1'b0;
                if (m_trap_after) begin m_req = 1'b0; m_trap = 1'b1; end
                else m_addr = m_pc;
            end
        end else if (m_valid) begin
            if (mis) begin m_mis = 1'b1; m_valid = 1'b0; m_trap = 1'b1; end
            else if (al) begin m_valid = 1'b0; m_pc = rpc; m_addr = rpc; m_req = 1'b1; end
            else if (!stall) begin
                m_valid = 1'b0; m_cnt = m_cnt + 32'd1;
                m_pc = m_pc + 32'd4; m_addr = m_pc; m_req = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req",   {31'd0, imem_req_o},    {31'd0, m_req});
        chk("valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("mis",   {31'd0, misaligned_o},  {31'd0, m_mis});
        chk("cnt",   fetch_cnt_o, m_cnt);
        chk("instr", instr_o,     m_instr);
        chk("ipc",   instr_pc_o,  m_ipc);
        if (m_req) chk("addr", imem_addr_o, m_addr);
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic tick(input logic redir, input logic [31:0] rpc, input logic ack_en,
                        input logic [31:0] rdata, input logic stall);
        logic ack;
        ack           = ack_en & imem_req_o;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_ack_i    = ack;
        imem_rdata_i  = rdata;
        stall_i       = stall;
        @(posedge clk);
        model_step(redir, rpc, ack, rdata, stall);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic do_reset();
        redirect_i = 1'b0; imem_ack_i = 1'b0; stall_i = 1'b0;
        rst_i = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        int trap_ticks;
        rst_i = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
        redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_i = 1'b0;
        model_reset();

        do_reset();
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);

        // Zero-wait sequential fetch from RESET_PC.
        tick(1'b0, 32'd0, 1'b1, word_for(imem_addr_o), 1'b0);
        chk("first_req", {31'd0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'd0, 1'b1, word_for(imem_addr_o), 1'b0);
            if (i == 0) chk("seq_pc0", instr_pc_o, 32'h0000_0100);
            if (i == 2) chk("seq_pc1", instr_pc_o, 32'h0000_0104);
            if (i == 4) chk("seq_pc2", instr_pc_o, 32'h0000_0108);
        end
        chk("seq_cnt", fetch_cnt_o, 32'd2);

        // Stall for three cycles in HOLD.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
            chk("stall_instr", instr_o, 32'hA5A5_0108);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
        end
        tick(1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        chk("stall_cnt", fetch_cnt_o, 32'd3);
        chk("next_addr", imem_addr_o, 32'h0000_010C);

        // Redirect while waiting for a slow memory.
        tick(1'b1, 32'h0000_0200, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("drain_addr", imem_addr_o, 32'h0000_010C);
        tick(1'b0, 32'd0, 1'b1, 32'h1111_1111, 1'b0);
        chk("drain_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("drain_next", imem_addr_o, 32'h0000_0200);

        // Redirect and ack in the same FETCH cycle.
        tick(1'b1, 32'h0000_0200, 1'b1, 32'h2222_2222, 1'b0);
        chk("same_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("same_addr", imem_addr_o, 32'h0000_0200);

        // PC wrap at the top of the address space.
        tick(1'b0, 32'd0, 1'b1, word_for(imem_addr_o), 1'b0);
        tick(1'b1, 32'hFFFF_FFFC, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 32'd0, 1'b1, word_for(imem_addr_o), 1'b0);
        chk("wrap_ipc", instr_pc_o, 32'hFFFF_FFFC);
        tick(1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        chk("wrap_addr", imem_addr_o, 32'h0000_0000);
        chk("wrap_cnt", fetch_cnt_o, 32'd4);

        // Randomized traffic.
        trap_ticks = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 300 == 299) || trap_ticks > 8) begin
                do_reset();
                trap_ticks = 0;
            end
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC;
            if ($urandom_range(0, 40) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            tick($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 2) == 0);
            if (m_trap) trap_ticks++;
        end

        // Misaligned redirect from HOLD: trapped until reset.
        do_reset();
        tick(1'b0, 32'd0, 1'b1, 32'h3333_3333, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 32'h3333_3333, 1'b1);
        tick(1'b1, 32'h0000_0202, 1'b1, 32'd0, 1'b0);
        chk("trap_mis", {31'd0, misaligned_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(i[0], 32'h0000_0400, 1'b1, 32'd0, 1'b0);
            chk("trap_req", {31'd0, imem_req_o}, 32'd0);
        end
        do_reset();
        chk("trap_clear", {31'd0, misaligned_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
